mem_access_unit: RTL and testbench

Data-memory access controller for the MEM stage of the pipelined RV32 core. It takes the load/store request held in the EX/MEM register, runs one transaction on the data-memory bus with a req/ack handshake, and stalls the pipeline until the access completes. It aligns and sign-extends load data and presents it as the `mem_in` source of the MEM/WB register, so it is the writer side of the MEM/WB register.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave):
// a single outstanding req/ack transaction with byte enables.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: one req/ack bus transaction per memory op, pipeline stall,
// load alignment/extension. Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access_unit (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_in,
  input  logic                     mem_read_in,
  input  logic                     mem_write_in,
  input  logic [2:0]               funct3_in,
  input  logic [31:0]              addr_in,
  input  logic [31:0]              store_data_in,
  mem_access_unit_if.master        bus,
  output logic [31:0]              mem_data_out,
  output logic                     stall_out,
  output logic                     bus_fault_out,
  output logic                     misalign_fault_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] mem_data_q;
  logic        bus_fault_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        size_byte;
  logic        size_half;
  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic [1:0]  lane_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    size_byte = (funct3_in[1:0] == 2'b00);
    size_half = (funct3_in[1:0] == 2'b01);
    mem_op    = valid_in && (mem_read_in || mem_write_in);

    // Address bits below the access size never select a lane.
    lane_d = 2'b00;
    if (size_byte)      lane_d = addr_in[1:0];
    else if (size_half) lane_d = {addr_in[1], 1'b0};

    be_d    = 4'b1111;
    wdata_d = store_data_in;
    if (size_byte) begin
      be_d    = 4'b0001 << lane_d;
      wdata_d = {4{store_data_in[7:0]}};
    end else if (size_half) begin
      be_d    = lane_d[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{store_data_in[15:0]}};
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_seen_q;
  logic misalign_q;
  logic mis_event;

  assign misaligned = (size_half && addr_in[0]) ||
                      (!size_byte && !size_half && (addr_in[1:0] != 2'b00));
  assign mis_event  = mem_op && misaligned && (state_q == IDLE) && !mis_seen_q;

  // The flag holds while EX/MEM keeps presenting the faulting op, so a held
  // instruction reports once; it drops as soon as something else is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_seen_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= mis_event;
      if (mis_event)                  mis_seen_q <= 1'b1;
      else if (!(mem_op && misaligned)) mis_seen_q <= 1'b0;
    end
  end

  assign misalign_fault_out = misalign_q;
`else
  assign misaligned         = 1'b0;
  assign misalign_fault_out = 1'b0;
`endif

  assign start     = mem_op && (state_q == IDLE) && !misaligned;
  assign stall_out = start || (state_q == BUSY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      mem_data_q  <= '0;
      bus_fault_q <= 1'b0;
      funct3_q    <= '0;
      lane_q      <= '0;
    end else begin
      bus_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_in;
            bus_addr_q  <= {addr_in[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            funct3_q    <= funct3_in;
            lane_q      <= lane_d;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            state_q     <= DONE;
            bus_req_q   <= 1'b0;
            bus_fault_q <= bus.bus_err;
            if (!bus_we_q)
              mem_data_q <= bus.bus_err ? '0 : fmt_load(bus.bus_rdata, funct3_q, lane_q);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
  assign mem_data_out  = mem_data_q;
  assign bus_fault_out = bus_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/bubble/misalign sequences,
// and random accesses checked against a byte-lane arithmetic model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data_in = '0;
  logic [31:0] mem_data_out;
  logic        stall_out;
  logic        bus_fault_out;
  logic        misalign_fault_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_mem = '0;

  mem_access_unit_if bif ();

  mem_access_unit dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .valid_in           (valid_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .funct3_in          (funct3_in),
    .addr_in            (addr_in),
    .store_data_in      (store_data_in),
    .bus                (bif),
    .mem_data_out       (mem_data_out),
    .stall_out          (stall_out),
    .bus_fault_out      (bus_fault_out),
    .misalign_fault_out (misalign_fault_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: size in bytes, natural lane offset, byte replication, extension.
  function automatic int sz_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int off_of(input logic [2:0] f3, input logic [31:0] addr);
    int a = int'(addr[1:0]);
    return a - (a % sz_of(f3));
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] m;
    m = 4'((1 << sz_of(f3)) - 1);
    return m << off_of(f3, addr);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int s = sz_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    longint unsigned v, mask;
    int s = sz_of(f3);
    v = longint'(rdata >> (8 * off_of(f3, addr)));
    if (s < 4) begin
      mask = (64'd1 << (8 * s)) - 1;
      v = v & mask;
      if (!f3[2] && v[8*s-1]) v = v | ~mask;
    end
    return v[31:0];
  endfunction

  // One full access from issue through DONE and one trailing idle cycle.
  task automatic run_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int dly, input logic e,
                            input logic [3:0] xbe, input logic [31:0] xwd, input logic [31:0] xld);
    int stalls;
    valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr;
    funct3_in = f3; addr_in = addr; store_data_in = data;
    @(negedge clk);
    chk({nm, " c0 stall"}, 32'(stall_out), 32'd1);
    chk({nm, " c0 req"}, 32'(bif.bus_req), 32'd0);
    stalls = 1;
    @(posedge clk); #1;
    for (int c = 1; c <= dly; c++) begin
      if (c == dly) begin
        bif.bus_ack = 1'b1; bif.bus_err = e; bif.bus_rdata = rdata;
      end else begin
        bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = $urandom;
      end
      @(negedge clk);
      chk({nm, " req"}, 32'(bif.bus_req), 32'd1);
      chk({nm, " we"}, 32'(bif.bus_we), 32'(wr));
      chk({nm, " addr"}, bif.bus_addr, addr & 32'hFFFF_FFFC);
      chk({nm, " be"}, 32'(bif.bus_be), 32'(xbe));
      if (wr) chk({nm, " wdata"}, bif.bus_wdata, xwd);
      chk({nm, " mem hold"}, mem_data_out, exp_mem);
      if (stall_out) stalls++;
      @(posedge clk); #1;
    end
    bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = $urandom;
    if (!wr) exp_mem = e ? 32'd0 : xld;
    @(negedge clk);
    chk({nm, " done stall"}, 32'(stall_out), 32'd0);
    chk({nm, " done req"}, 32'(bif.bus_req), 32'd0);
    chk({nm, " done fault"}, 32'(bus_fault_out), 32'(e));
    chk({nm, " done mis"}, 32'(misalign_fault_out), 32'd0);
    chk({nm, " mem_data"}, mem_data_out, exp_mem);
    chk({nm, " stall cycles"}, 32'(stalls), 32'(dly + 1));
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    @(negedge clk);
    chk({nm, " idle fault"}, 32'(bus_fault_out), 32'd0);
    chk({nm, " idle stall"}, 32'(stall_out), 32'd0);
    chk({nm, " idle req"}, 32'(bif.bus_req), 32'd0);
    chk({nm, " idle mem"}, mem_data_out, exp_mem);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          dly;
    logic        e;
    logic [3:0]  xbe;
    logic [31:0] xwd;
    logic [31:0] xld;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"lw100",   1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 4'b1111, 32'h0, 32'hDEADBEEF});
    vecs.push_back('{"lb103",   1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 4'b1000, 32'h0, 32'hFFFFFF80});
    vecs.push_back('{"lbu103",  1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2, 0, 4'b1000, 32'h0, 32'h00000080});
    vecs.push_back('{"sh202",   0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 4'b1100, 32'hABCDABCD, 32'h0});
    vecs.push_back('{"lw_err",  1, 0, 3'b010, 32'h300, 32'h0, 32'h12345678, 1, 1, 4'b1111, 32'h0, 32'h0});
    vecs.push_back('{"lh102",   1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1, 0, 4'b1100, 32'h0, 32'hFFFF8001});
    vecs.push_back('{"lhu100",  1, 0, 3'b101, 32'h100, 32'h0, 32'h80017FFF, 2, 0, 4'b0011, 32'h0, 32'h00007FFF});
    vecs.push_back('{"sb101",   0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1, 0, 4'b0010, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{"sw_rdwr", 1, 1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 2, 0, 4'b1111, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{"lw_f3_7", 1, 0, 3'b111, 32'h44, 32'h0, 32'h87654321, 1, 0, 4'b1111, 32'h0, 32'h87654321});
    vecs.push_back('{"sw_err",  0, 1, 3'b010, 32'h48, 32'h11112222, 32'h0, 1, 1, 4'b1111, 32'h11112222, 32'h0});
`ifndef MEM_ALIGN_CHECK_EN
    vecs.push_back('{"lw102",   1, 0, 3'b010, 32'h102, 32'h0, 32'hA1B2C3D4, 1, 0, 4'b1111, 32'h0, 32'hA1B2C3D4});
    vecs.push_back('{"lh103",   1, 0, 3'b001, 32'h103, 32'h0, 32'h80017FFF, 1, 0, 4'b1100, 32'h0, 32'hFFFF8001});
`endif
  end

  initial begin
    int pulses;
    bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst req", 32'(bif.bus_req), 32'd0);
    chk("rst we", 32'(bif.bus_we), 32'd0);
    chk("rst addr", bif.bus_addr, 32'd0);
    chk("rst wdata", bif.bus_wdata, 32'd0);
    chk("rst be", 32'(bif.bus_be), 32'd0);
    chk("rst mem", mem_data_out, 32'd0);
    chk("rst stall", 32'(stall_out), 32'd0);
    chk("rst fault", 32'(bus_fault_out), 32'd0);
    chk("rst mis", 32'(misalign_fault_out), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_access(vecs[i].nm, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].data,
                 vecs[i].rdata, vecs[i].dly, vecs[i].e, vecs[i].xbe, vecs[i].xwd, vecs[i].xld);

    // Bubble and non-memory op: no request, no stall, stray ack ignored.
    valid_in = 1'b0; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h500;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin valid_in = 1'b1; mem_read_in = 1'b0; end
      bif.bus_ack = (c == 2); bif.bus_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      chk("bubble req", 32'(bif.bus_req), 32'd0);
      chk("bubble stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("bubble mem", mem_data_out, exp_mem);
    end
    bif.bus_ack = 1'b0; valid_in = 1'b0;

    // Reset while BUSY, then a late ack.
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy req", 32'(bif.bus_req), 32'd1);
    #1 reset_n = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0;
    #1;
    chk("rstbusy req0", 32'(bif.bus_req), 32'd0);
    chk("rstbusy stall0", 32'(stall_out), 32'd0);
    exp_mem = 32'd0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late ack stall", 32'(stall_out), 32'd0);
    chk("late ack req", 32'(bif.bus_req), 32'd0);
    @(posedge clk); #1 bif.bus_ack = 1'b0;
    @(negedge clk);
    chk("late ack mem", mem_data_out, exp_mem);
    chk("late ack fault", 32'(bus_fault_out), 32'd0);
    chk("late ack req2", 32'(bif.bus_req), 32'd0);
    @(posedge clk); #1;

    // Misaligned word held for several cycles.
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h102;
    pulses = 0;
`ifdef MEM_ALIGN_CHECK_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mis stall", 32'(stall_out), 32'd0);
      chk("mis req", 32'(bif.bus_req), 32'd0);
      chk("mis pulse timing", 32'(misalign_fault_out), 32'(c == 1));
      if (misalign_fault_out) pulses++;
      @(posedge clk); #1;
    end
    chk("mis pulses", 32'(pulses), 32'd1);
    chk("mis mem", mem_data_out, exp_mem);
    valid_in = 1'b0; mem_read_in = 1'b0;
    @(posedge clk); #1;
`else
    @(negedge clk);
    chk("nochk stall", 32'(stall_out), 32'd1);
    @(posedge clk); #1 bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("nochk addr", bif.bus_addr, 32'h100);
    chk("nochk mis", 32'(misalign_fault_out), 32'd0);
    if (misalign_fault_out) pulses++;
    @(posedge clk); #1 bif.bus_ack = 1'b0;
    exp_mem = 32'h0BADF00D;
    @(negedge clk);
    chk("nochk mem", mem_data_out, exp_mem);
    chk("nochk pulses", 32'(pulses), 32'd0);
    @(posedge clk); #1 valid_in = 1'b0; mem_read_in = 1'b0;
    @(posedge clk); #1;
`endif

    // Random accesses against the model.
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] addr, data, rdata;
      logic        rd, wr, e;
      int          op, dly;
      f3 = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 2);
      rd = (op != 1); wr = (op != 0);
      addr = $urandom; data = $urandom; rdata = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      addr = addr & ~32'(sz_of(f3) - 1);
`endif
      dly = $urandom_range(1, 4);
      e = ($urandom_range(0, 7) == 0);
      run_access("rnd", rd, wr, f3, addr, data, rdata, dly, e,
                 ref_be(f3, addr), ref_wdata(f3, data), ref_load(f3, addr, rdata));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
